// File: rtl/tdm_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tdm_voice_mixer
// Brief    : Four-voice square-wave synthesiser with decaying envelopes,
//            mixed over a 4-slot TDM frame into one 8-bit sample per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_voice_mixer #(
    parameter int DIV_W       = 12,
    parameter int DECAY_SHIFT = 14,
    parameter int MIN_LEVEL   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       slot,
    input  logic [DIV_W-1:0] divider,
    output logic [7:0]       sample,
    output logic             sample_valid
);

    localparam logic [3:0]             c_min_level = 4'(MIN_LEVEL);
    localparam logic [3:0]             c_max_level = 4'd15;
    localparam logic [DIV_W-1:0]       c_div_one   = DIV_W'(1);
    localparam logic [DECAY_SHIFT-1:0] c_frame_one = DECAY_SHIFT'(1);

    logic [DIV_W-1:0]       phase_q    [4];
    logic [DIV_W-1:0]       phase_d    [4];
    logic                   sq_q       [4];
    logic                   sq_d       [4];
    logic [3:0]             level_q    [4];
    logic [3:0]             level_d    [4];
    logic [DIV_W-1:0]       last_div_q [4];
    logic [DIV_W-1:0]       last_div_d [4];

    logic [DECAY_SHIFT-1:0] frame_cnt_q, frame_cnt_d;
    logic [6:0]             acc_q, acc_d;
    logic [7:0]             sample_q, sample_d;
    logic                   sample_valid_q, sample_valid_d;

    logic                   w_retrig;
    logic                   w_decay_tick;
    logic                   w_frame_end;
    logic [6:0]             w_contrib;
    logic [6:0]             w_sum;

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

    // Contribution always uses the pre-edge state; voice 0 is weighted double.
    always_comb begin
        w_contrib = 7'd0;
        if (sq_q[slot]) begin
            if (slot == 2'd0) begin
                w_contrib = {2'b00, level_q[slot], 1'b0};
            end else begin
                w_contrib = {3'b000, level_q[slot]};
            end
        end
    end

    assign w_frame_end  = (slot == 2'd3);
    assign w_decay_tick = w_frame_end && (frame_cnt_q == '1);
    assign w_sum        = acc_q + w_contrib;

    always_comb begin
        phase_d    = phase_q;
        sq_d       = sq_q;
        level_d    = level_q;
        last_div_d = last_div_q;
        w_retrig   = 1'b0;

        if (divider == '0) begin
            phase_d[slot]    = '0;
            sq_d[slot]       = 1'b0;
            last_div_d[slot] = '0;
        end else if (divider != last_div_q[slot]) begin
            phase_d[slot]    = '0;
            sq_d[slot]       = 1'b0;
            level_d[slot]    = c_max_level;
            last_div_d[slot] = divider;
            w_retrig         = 1'b1;
        end else if (phase_q[slot] >= (divider - c_div_one)) begin
            phase_d[slot] = '0;
            sq_d[slot]    = ~sq_q[slot];
        end else begin
            phase_d[slot] = phase_q[slot] + c_div_one;
        end

        // Levels below the floor (only reachable from reset) are left alone.
        if (w_decay_tick) begin
            for (int v = 0; v < 4; v++) begin
                if (!(w_retrig && (2'(v) == slot)) && (level_q[v] > c_min_level)) begin
                    level_d[v] = level_q[v] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        acc_d          = acc_q;
        sample_d       = sample_q;
        frame_cnt_d    = frame_cnt_q;
        sample_valid_d = 1'b0;

        if (w_frame_end) begin
            sample_d       = {w_sum, 1'b0};
            sample_valid_d = 1'b1;
            frame_cnt_d    = frame_cnt_q + c_frame_one;
        end else if (slot == 2'd0) begin
            acc_d = w_contrib;
        end else begin
            acc_d = w_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 4; v++) begin
                phase_q[v]    <= '0;
                sq_q[v]       <= 1'b0;
                level_q[v]    <= 4'd0;
                last_div_q[v] <= '0;
            end
            frame_cnt_q    <= '0;
            acc_q          <= 7'd0;
            sample_q       <= 8'd0;
            sample_valid_q <= 1'b0;
        end else begin
            for (int v = 0; v < 4; v++) begin
                phase_q[v]    <= phase_d[v];
                sq_q[v]       <= sq_d[v];
                level_q[v]    <= level_d[v];
                last_div_q[v] <= last_div_d[v];
            end
            frame_cnt_q    <= frame_cnt_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdm_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_voice_mixer
// Brief    : Directed self-checking bench; a slow-decay and a fast-decay
//            instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_voice_mixer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  slot = 2'd0;
    logic [11:0] divider = 12'd0;
    logic [7:0]  sample_slow, sample_fast;
    logic        valid_slow, valid_fast;

    logic [11:0] div [4];
    logic [7:0]  smp_slow, smp_fast;
    logic        vhist [4];
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    int          misplaced = 0;

    always #5 clk = ~clk;

    tdm_voice_mixer #(.DIV_W(12), .DECAY_SHIFT(14), .MIN_LEVEL(4)) u_dut_slow (
        .clk(clk), .rst(rst), .slot(slot), .divider(divider),
        .sample(sample_slow), .sample_valid(valid_slow)
    );

    tdm_voice_mixer #(.DIV_W(12), .DECAY_SHIFT(2), .MIN_LEVEL(4)) u_dut_fast (
        .clk(clk), .rst(rst), .slot(slot), .divider(divider),
        .sample(sample_fast), .sample_valid(valid_fast)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts and ends just after a falling edge; inputs change only there.
    task automatic cycle(input logic [1:0] s);
        slot    = s;
        divider = div[s];
        @(posedge clk);
        #1;
        vhist[s] = valid_slow;
        if (valid_slow) pulses++;
        if (valid_slow != (s == 2'd3)) misplaced++;
        @(negedge clk);
    endtask

    task automatic frame();
        for (int s = 0; s < 4; s++) begin
            cycle(2'(s));
            if (s == 3) begin
                smp_slow = sample_slow;
                smp_fast = sample_fast;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < 4; v++) div[v] = 12'd0;

        // Power-on reset
        #1 rst = 1'b1;
        #1;
        check("por_sample_slow", 16'(sample_slow), 16'd0);
        check("por_valid_slow",  16'(valid_slow),  16'd0);
        check("por_sample_fast", 16'(sample_fast), 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single voice: voice 1 divider 3
        div[1] = 12'd3;
        for (int f = 1; f <= 13; f++) begin
            frame();
            check("single_voice", 16'(smp_slow),
                  ((f >= 5 && f <= 7) || (f >= 11)) ? 16'd30 : 16'd0);
            if (f == 1) check("single_valid", 16'(vhist[3]), 16'd1);
        end

        // Full scale: all voices at divider 1
        do_reset();
        for (int v = 0; v < 4; v++) div[v] = 12'd1;
        for (int f = 1; f <= 5; f++) begin
            frame();
            check("full_scale", 16'(smp_slow), (f == 3 || f == 5) ? 16'd150 : 16'd0);
            if (f == 3) check("full_scale_fast_f3", 16'(smp_fast), 16'd150);
            if (f == 5) check("full_scale_fast_f5", 16'(smp_fast), 16'd140);
        end
        check("pre_reset_valid", 16'(valid_slow), 16'd1);

        // Asynchronous reset mid-frame, no clock edge in between
        #1 rst = 1'b1;
        #1;
        check("async_rst_sample", 16'(sample_slow), 16'd0);
        check("async_rst_valid",  16'(valid_slow),  16'd0);
        @(negedge clk);
        rst = 1'b0;
        frame();
        check("post_rst_valid_s0", 16'(vhist[0]), 16'd0);
        check("post_rst_valid_s2", 16'(vhist[2]), 16'd0);
        check("post_rst_valid_s3", 16'(vhist[3]), 16'd1);
        check("post_rst_sample",   16'(smp_slow), 16'd0);

        // Decay on voice 2 (fast instance), then retrigger with a new divider
        do_reset();
        div[0] = 12'd0; div[1] = 12'd0; div[2] = 12'd1; div[3] = 12'd0;
        for (int f = 1; f <= 67; f++) begin
            frame();
            case (f)
                3:  check("decay_f3",  16'(smp_fast), 16'd30);
                4:  check("decay_f4",  16'(smp_fast), 16'd0);
                5:  check("decay_f5",  16'(smp_fast), 16'd28);
                9:  check("decay_f9",  16'(smp_fast), 16'd26);
                13: check("decay_f13", 16'(smp_fast), 16'd24);
                43: check("decay_f43", 16'(smp_fast), 16'd10);
                49: check("decay_f49", 16'(smp_fast), 16'd8);
                61: check("decay_f61", 16'(smp_fast), 16'd8);
                62: check("retrig_f62", 16'(smp_fast), 16'd0);
                63: check("retrig_f63", 16'(smp_fast), 16'd0);
                65: check("retrig_f65", 16'(smp_fast), 16'd28);
                66: check("retrig_f66", 16'(smp_fast), 16'd28);
                67: check("retrig_f67", 16'(smp_fast), 16'd0);
                default: ;
            endcase
            if (f == 61) div[2] = 12'd2;
        end

        // Silence on voice 0, then retrigger
        do_reset();
        div[0] = 12'd1; div[1] = 12'd0; div[2] = 12'd0; div[3] = 12'd0;
        for (int f = 1; f <= 10; f++) begin
            if (f == 5) div[0] = 12'd0;
            if (f == 8) div[0] = 12'd1;
            frame();
            case (f)
                3:  check("cello_f3",      16'(smp_slow), 16'd60);
                5:  check("silence_f5",    16'(smp_slow), 16'd60);
                6:  check("silence_f6",    16'(smp_slow), 16'd0);
                7:  check("silence_f7",    16'(smp_slow), 16'd0);
                9:  check("resume_f9",     16'(smp_slow), 16'd0);
                10: begin
                    check("resume_f10",      16'(smp_slow), 16'd60);
                    check("resume_f10_fast", 16'(smp_fast), 16'd56);
                end
                default: ;
            endcase
        end

        // Strobe cadence over 1000 free-running cycles
        do_reset();
        div[0] = 12'd5; div[1] = 12'd7; div[2] = 12'd0; div[3] = 12'd2;
        pulses    = 0;
        misplaced = 0;
        for (int i = 0; i < 1000; i++) cycle(2'(i % 4));
        check("strobe_count",     16'(pulses),    16'd250);
        check("strobe_misplaced", 16'(misplaced), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_voice_mixer.md
# tdm_voice_mixer

Four-voice square-wave synthesiser and mixer fed by the music sequencer's time-multiplexed divider bus. Each clock serves one voice slot. The block keeps a phase counter, a square-wave state and a decaying 4-bit envelope for each voice. It sums the four voice contributions over one 4-cycle frame and delivers one 8-bit sample per frame to the PWM output stage.

## Interface
Parameters:
- `DIV_W`, 12, divider width; a divider value of 0 means the voice is silent.
- `DECAY_SHIFT`, 14, envelope decay tick period of 2^DECAY_SHIFT frames.
- `MIN_LEVEL`, 4, envelope floor (0..15).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; the block has one clock, and this reset is asynchronous and active-high.
- `slot`  in  2  voice index served this cycle; the upstream sequencer advances it by 1 (mod 4) every cycle.
- `divider`  in  DIV_W  half-period, in frames, for voice `slot`.
- `sample`  out  8  mixed sample; registered.
- `sample_valid`  out  1  one-cycle strobe, high in the cycle after `sample` updates.

## Operation
Per-voice state, v = 0..3:
- `phase[v]`, DIV_W bits.
- `sq[v]`, 1 bit.
- `level[v]`, 4 bits.
- `last_div[v]`, DIV_W bits.

Global state:
- `frame_cnt`, DECAY_SHIFT bits.
- `acc`, 7 bits.

All of the following happen at the rising edge of a cycle, with v = `slot`:
- **Contribution.** c = `sq[v]` ? `level[v]` : 0, using pre-edge values. Voice 0 (cello) counts double: c0 = `level` << 1. Maximum frame sum is 30 + 3×15 = 75, which fits `acc`.
- **Silent voice.** If `divider` == 0: `phase[v]` <= 0, `sq[v]` <= 0, `level[v]` unchanged, `last_div[v]` <= 0.
- **Retrigger.** Else if `divider` != `last_div[v]`: `phase[v]` <= 0, `sq[v]` <= 0, `level[v]` <= 15, `last_div[v]` <= `divider`. A change from 0 to nonzero also retriggers.
- **Toggle.** Else if `phase[v]` >= `divider` − 1: `phase[v]` <= 0, `sq[v]` <= ~`sq[v]`.
- **Count.** Else `phase[v]` <= `phase[v]` + 1.
- **Decay.** When `frame_cnt` == all-ones at the slot-3 edge, every voice not retriggered in that cycle gets `level` <= max(`level` − 1, MIN_LEVEL). A voice with `level` < MIN_LEVEL (only possible after reset) is left unchanged.
- **Accumulate.** Slots 0–2: `acc` <= (slot==0 ? 0 : `acc`) + c.
- **Frame end.** Slot 3: `sample` <= {(`acc` + c), 1'b0}, giving a range of 0..150. In the same edge `sample_valid` <= 1 and `frame_cnt` <= `frame_cnt` + 1.
- **Strobe.** At every other edge, `sample_valid` <= 0.
- **Resulting frequency.** Square frequency = f_clk / (8 × `divider`).
- **Divider of 1.** With `divider` == 1, the square toggles every frame.

## Timing
- **Reset state.** While `rst` is high: all `phase`, `sq`, `level`, `last_div`, `acc` and `frame_cnt` = 0; `sample` = 0; `sample_valid` = 0. These apply immediately, with no clock needed.
- **Reset release.** The first served slot after release is processed normally.
- **Reset mid-frame.** Asserting `rst` mid-frame discards the partial `acc`; no `sample_valid` pulse is produced for that frame.
- **Latency.** A voice state change made at its slot edge in frame N is first reflected in the `sample` written at the slot-3 edge of frame N+1. Exception: voice 3, whose new state is visible from the next frame's slot-3 edge, i.e. also frame N+1.
- **Sample update.** `sample` changes only at slot-3 edges and is stable for 4 cycles. `sample_valid` is high exactly 1 of every 4 cycles, in the slot-0 cycle.
- **Out-of-order slot.** If `slot` sequence is violated, the same per-edge rules apply. There is no error detection. `acc` is cleared only on slot 0.
- **Phase overflow.** `phase` never exceeds `divider` − 1. If `divider` shrinks below the current `phase` with the same `last_div`, that cannot occur, because any change retriggers.

## Test plan
- **Reset:** assert `rst` asynchronously mid-frame with all voices active -> `sample` = 0 and `sample_valid` = 0 immediately; the first `sample_valid` comes at the first slot-3 edge after release, with `sample` = 0.
- **Single voice:** voice 1 `divider` = 3, others 0, `DECAY_SHIFT` forced large -> `sq[1]` toggles every 3 frames; `sample` alternates 0 and 30 (level 15 × 2) in runs of 3 frames.
- **Cello weighting / full scale:** all four voices at divider 1 with aligned phase -> `sample` alternates 0 and 150.
- **Retrigger and decay:** `DECAY_SHIFT` = 2, voice 2 steady -> level falls 15→14→… one step per 4 frames and holds at MIN_LEVEL = 4 (`sample` peak 8). Changing voice 2's divider then restores level 15, with phase 0 and `sq` 0.
- **Silence:** set voice 0 `divider` to 0 while its `sq` = 1 -> contribution 0 from the next frame; level retained; a later nonzero divider retriggers to 15.
- **Strobe cadence:** 1000 free-running cycles -> exactly 250 `sample_valid` pulses, each in the slot-0 cycle.
